// File: rtl/hdb3_dac_tx.sv
// HDB3 line encoder feeding an 8-bit DAC: one symbol every 16 clk_in cycles,
// source bits pass through a 4-deep tag line so B00V substitution can be applied retroactively.
module hdb3_dac_tx #(
    parameter logic [7:0] LVL_P = 8'hFF,
    parameter logic [7:0] LVL_Z = 8'h80,
    parameter logic [7:0] LVL_N = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    input  logic       data_in,
    output logic       data_req,
    output logic       sym_clk,
    output logic [7:0] dac_out,
    output logic       code_p,
    output logic       code_n
);
    typedef enum logic [1:0] {T_ZERO, T_ONE, T_B, T_V} tag_t;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       strobe;
    tag_t       line [4];
    logic [1:0] run;
    logic       parity;
    logic       last_pol;   // 1 = last mark was positive

    tag_t       new_tag;
    logic       retag_b;
    logic [7:0] lvl_nxt;
    logic       p_nxt;
    logic       n_nxt;
    logic       pol_nxt;

    assign cnt_nxt = cnt + 4'd1;
    assign strobe  = (cnt == 4'd15);

    // Stage one: tag the incoming bit; a V with even parity turns the run's first zero into B.
    always_comb begin
        new_tag = T_ZERO;
        if (data_in)
            new_tag = T_ONE;
        else if (run == 2'd3)
            new_tag = T_V;
        retag_b = (new_tag == T_V) && !parity;
    end

    // Line coder for the tag leaving the delay line.
    always_comb begin
        pol_nxt = last_pol;
        lvl_nxt = LVL_Z;
        p_nxt   = 1'b0;
        n_nxt   = 1'b0;
        case (line[3])
            T_ONE, T_B: begin
                pol_nxt = ~last_pol;
                if (!last_pol) begin
                    lvl_nxt = LVL_P;
                    p_nxt   = 1'b1;
                end else begin
                    lvl_nxt = LVL_N;
                    n_nxt   = 1'b1;
                end
            end
            T_V: begin
                if (last_pol) begin
                    lvl_nxt = LVL_P;
                    p_nxt   = 1'b1;
                end else begin
                    lvl_nxt = LVL_N;
                    n_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n || !en) begin
            cnt      <= 4'd0;
            sym_clk  <= 1'b0;
            data_req <= 1'b0;
            dac_out  <= LVL_Z;
            code_p   <= 1'b0;
            code_n   <= 1'b0;
            run      <= 2'd0;
            parity   <= 1'b0;
            last_pol <= 1'b0;
            for (int i = 0; i < 4; i++)
                line[i] <= T_ZERO;
        end else begin
            cnt      <= cnt_nxt;
            sym_clk  <= ~cnt_nxt[3];
            data_req <= (cnt_nxt == 4'd14);
            if (strobe) begin
                dac_out  <= lvl_nxt;
                code_p   <= p_nxt;
                code_n   <= n_nxt;
                last_pol <= pol_nxt;
                line[0]  <= new_tag;
                line[1]  <= line[0];
                line[2]  <= line[1];
                line[3]  <= retag_b ? T_B : line[2];
                case (new_tag)
                    T_ONE: begin
                        run    <= 2'd0;
                        parity <= ~parity;
                    end
                    T_V: begin
                        run    <= 2'd0;
                        parity <= 1'b0;
                    end
                    default: run <= run + 2'd1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hdb3_dac_tx.sv
// Table-driven bench for hdb3_dac_tx: bit strings in, expected line symbols queued per bit.
module tb_hdb3_dac_tx;
    logic       clk_in;
    logic       rst_n;
    logic       en;
    logic       data_in;
    logic       data_req;
    logic       sym_clk;
    logic [7:0] dac_out;
    logic       code_p;
    logic       code_n;

    hdb3_dac_tx dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .data_in (data_in),
        .data_req(data_req),
        .sym_clk (sym_clk),
        .dac_out (dac_out),
        .code_p  (code_p),
        .code_n  (code_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        string name;
        string bits;
        string syms;   // P = positive, Z = zero, N = negative, one per bit
    } vec_t;

    typedef struct {
        int lvl;
        int p;
        int n;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];
    int   lat_q [$];
    bit   bit_q [$];

    int n_vec;
    int n_err;
    int cyc;
    bit mon_en;
    bit req_d1, req_d2;
    bit prev_sym;
    int prev_dac;
    int last_strobe;
    int hi_cnt;

    task automatic chk(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
        end
    endtask

    function automatic exp_t sym2exp(input byte c);
        exp_t e;
        e.lvl = 'h80; e.p = 0; e.n = 0;
        if (c == "P") begin e.lvl = 'hFF; e.p = 1; end
        else if (c == "N") begin e.lvl = 'h00; e.n = 1; end
        return e;
    endfunction

    task automatic tick();
        bit   rise, stb;
        exp_t e;
        int   t;
        @(negedge clk_in);
        cyc++;
        if (mon_en) begin
            rise = sym_clk && !prev_sym;
            stb  = req_d2;
            if (data_req) chk("req_one_cycle", int'(req_d1), 0);
            req_d2 = req_d1;
            req_d1 = data_req;
            if (int'(dac_out) != prev_dac) chk("dac_change_on_strobe", int'(stb), 1);
            if (stb) begin
                chk("symclk_rise_at_strobe", int'(rise), 1);
                chk("flags_exclusive", int'(code_p & code_n), 0);
                if (last_strobe >= 0) begin
                    chk("sym_period", cyc - last_strobe, 16);
                    chk("sym_high", hi_cnt, 8);
                end
                last_strobe = cyc;
                hi_cnt = 0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("dac_out", int'(dac_out), e.lvl);
                    chk("code_pn", int'({code_p, code_n}), (e.p << 1) | e.n);
                end
                if (lat_q.size() > 0) begin
                    t = lat_q.pop_front();
                    if (t >= 0) chk("latency", cyc - t, 64);
                end
            end
            hi_cnt += int'(sym_clk);
            // Source side: present the next bit when requested, pad with ones when out of bits.
            if (data_req) begin
                if (bit_q.size() > 0) begin
                    data_in = bit_q.pop_front();
                    lat_q.push_back(cyc + 2);
                end else begin
                    data_in = 1'b1;
                end
            end
            prev_sym = sym_clk;
            prev_dac = int'(dac_out);
        end
    endtask

    task automatic restart(input bit use_en);
        exp_t z;
        mon_en = 0;
        if (use_en) en = 1'b0; else rst_n = 1'b0;
        tick();
        chk(use_en ? "en_off_dac" : "rst_dac", int'(dac_out), 'h80);
        chk(use_en ? "en_off_symclk" : "rst_symclk", int'(sym_clk), 0);
        chk(use_en ? "en_off_req" : "rst_req", int'(data_req), 0);
        chk(use_en ? "en_off_flags" : "rst_flags", int'({code_p, code_n}), 0);
        en = 1'b1;
        rst_n = 1'b1;
        exp_q.delete();
        lat_q.delete();
        bit_q.delete();
        z = sym2exp("Z");
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(z);
            lat_q.push_back(-1);
        end
        req_d1 = 0; req_d2 = 0;
        prev_sym = sym_clk;
        prev_dac = int'(dac_out);
        last_strobe = -1;
        hi_cnt = 0;
        mon_en = 1;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < v.bits.len(); i++) begin
            bit_q.push_back(v.bits.getc(i) == "1");
            exp_q.push_back(sym2exp(v.syms.getc(i)));
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || bit_q.size() > 0) && k < 3000) begin
            tick();
            k++;
        end
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        mon_en = 0;
        rst_n = 1'b0; en = 1'b1; data_in = 1'b0;

        vecs[0] = '{"all_ones",  "11111111",     "PNPNPNPN"};
        vecs[1] = '{"all_zeros", "000000000000", "PZZPNZZNPZZP"};
        vecs[2] = '{"v_odd",     "10000",        "PZZZP"};
        vecs[3] = '{"b00v",      "110000",       "PNPZZP"};
        vecs[4] = '{"mixed",     "10100001",     "PZNPZZPN"};
        vecs[5] = '{"run_break", "00010000",     "ZZZPZZZP"};

        restart(0);
        for (int v = 0; v < 6; v++) begin
            load(vecs[v]);
            drain(vecs[v].name);
            restart(v[0]);
        end

        // Drop en mid-stream; pending symbols vanish and coding state starts fresh.
        load(vecs[0]);
        for (int i = 0; i < 100; i++) tick();
        restart(1);
        load(vecs[3]);
        drain("after_en_drop");

        // One-cycle reset pulse mid-stream.
        restart(0);
        load(vecs[0]);
        for (int i = 0; i < 90; i++) tick();
        restart(0);
        load(vecs[2]);
        drain("after_rst_pulse");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
